fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised, compacting, multi-in/multi-out instruction queue between pre-decode and decode. Supersedes the fixed 3-wide fetch FIFO.
- Accepts up to FETCH_WIDTH fetched slots per cycle under a sparse valid mask and packs them in program order.
- Presents up to DECODE_WIDTH oldest entries per cycle; decode acknowledges a variable count.
- Each entry carries branch-prediction metadata.

Parameters:
FETCH_WIDTH, 3, slots written per cycle (1..8)
DECODE_WIDTH, 3, slots presented per cycle (1..8)
DEPTH, 16, entries; power of two, DEPTH >= 2*FETCH_WIDTH
INDEX_W, 10, PHT index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all entries (branch mispredict / ROB recovery)
enq_valid  in  [FETCH_WIDTH] x 1  per-slot valid from pre-decode, may be sparse
enq_pc, enq_inst, enq_target_unsel  in  [FETCH_WIDTH] x 32  slot PC, instruction, unselected target
enq_index  in  [FETCH_WIDTH] x INDEX_W  PHT index
enq_predict  in  [FETCH_WIDTH] x 1  predicted taken
enq_ready  out  1  at least FETCH_WIDTH free entries; drives fetch stall
deq_valid  out  [DECODE_WIDTH] x 1  lane i valid iff count > i
deq_pc, deq_inst, deq_target_unsel  out  [DECODE_WIDTH] x 32  oldest-first entry fields
deq_index  out  [DECODE_WIDTH] x INDEX_W
deq_predict  out  [DECODE_WIDTH] x 1
deq_ack  in  clog2(DECODE_WIDTH+1)  entries consumed this cycle
count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset, synchronous on clk when rst=1: head=tail=count=0, all storage zeroed, deq_valid=0, deq data=0, enq_ready=1.
- enq_ready = (DEPTH - count) >= FETCH_WIDTH, from registered count only. No same-cycle dequeue credit, so no combinational path from deq_ack.
- Enqueue fires when enq_ready && |enq_valid.
  - Valid slots are compacted by prefix sum: slot i goes to tail + (number of valid slots below i), modulo DEPTH.
  - tail advances by popcount(enq_valid).
  - Invalid slots are never written.
- If enq_ready=0, inputs are ignored. Upstream holds its data via stall.
- Dequeue: lane j shows entry head+j mod DEPTH; deq_valid[j] = (count > j).
  - Output latency is combinational from storage, so an entry is visible one cycle after enqueue.
  - head advances by deq_ack.
  - deq_ack > count is illegal; the implementation clamps to count and fires an assertion in simulation.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq. Full-depth use is allowed.
- Pointers wrap modulo DEPTH. A write or read group may straddle the wrap point.
- flush has priority over enqueue and dequeue in the same cycle: head=tail=count=0, deq_valid=0 next cycle. Storage contents are left stale.
- rst has priority over flush.
- Empty queue: deq_valid all 0, deq_ack must be 0.

Optional Feature:
Macro FETCH_QUEUE_PERF_EN.
- Defined: adds outputs perf_full_cycles and perf_empty_cycles, each 32 bits, saturating at 0xFFFFFFFF, cleared by rst only (flush does not clear).
  - perf_full_cycles counts cycles with enq_ready=0 && |enq_valid.
  - perf_empty_cycles counts cycles with count=0.
- Undefined: the ports and counters do not exist; function is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_entry_t struct: pc, inst, target_unsel, index, predict.
  - Defaults FETCH_WIDTH_D, DECODE_WIDTH_D, FQ_DEPTH_D, PHT_INDEX_W.
- Sub-module fetch_compact (combinational): enq_valid mask -> per-slot write offsets and total popcount.
- Storage and pointer logic stay in fetch_queue.

Test Plan:
- Reset, then enq_valid=3'b101 with PCs 0x1c000000/04/08 -> next cycle count=2, deq_valid=3'b011, deq_pc[0]=0x1c000000, deq_pc[1]=0x1c000008.
- Fill: DEPTH=16, enqueue 3'b111 for 5 cycles with no dequeue -> count=15, enq_ready=0. A sixth enqueue is dropped; count stays 15.
- Wrap: preload head=tail=14, enqueue 3 entries with deq_ack=0 -> entries land at 14, 15, 0. Subsequent dequeue order matches PC order.
- Simultaneous: count=4, enqueue 3'b111 and deq_ack=2 in the same cycle -> count=5; deq_pc[0] equals the third-oldest prior entry.
- Flush: count=9, same cycle as enqueue 3'b111 and deq_ack=3 -> count=0, deq_valid=0, tail=head=0.
- With FETCH_QUEUE_PERF_EN: hold enq_valid=3'b111 while full for 7 cycles -> perf_full_cycles=7; flush leaves it at 7.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch queue between pre-decode and decode.
package fetch_pkg;

   localparam int FETCH_WIDTH_D  = 3;
   localparam int DECODE_WIDTH_D = 3;
   localparam int FQ_DEPTH_D     = 16;
   localparam int PHT_INDEX_W    = 10;

   typedef struct packed {
      logic [31:0]            pc;
      logic [31:0]            inst;
      logic [31:0]            target_unsel;
      logic [PHT_INDEX_W-1:0] index;
      logic                   predict;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_compact.sv
// Combinational packer: turns a sparse slot-valid mask into per-slot write offsets
// (count of valid slots below each slot) and the total number of valid slots.
module fetch_compact
   import fetch_pkg::*;
#(
   parameter int WIDTH = FETCH_WIDTH_D,
   parameter int OFF_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]       valid,
   output logic [WIDTH*OFF_W-1:0] offset,
   output logic [OFF_W-1:0]       total
);

   logic [OFF_W-1:0] run_s;

   // exclusive prefix sum over the valid mask
   always_comb begin
      run_s  = '0;
      offset = '0;
      for (int i = 0; i < WIDTH; i++) begin
         offset[i*OFF_W +: OFF_W] = run_s;
         if (valid[i]) begin
            run_s = run_s + OFF_W'(1);
         end else begin
            run_s = run_s;
         end
      end
      total = run_s;
   end

endmodule

// File: rtl/fetch_queue_chk.sv
// Simulation checker for the fetch queue decode handshake.
module fetch_queue_chk #(
   parameter int CNT_W = 5,
   parameter int ACK_W = 2
) (
   input logic             clk,
   input logic             rst,
   input logic [ACK_W-1:0] deq_ack,
   input logic [CNT_W-1:0] count
);

   // decode may never acknowledge more entries than are presented
   ack_within_count: assert property (@(posedge clk) disable iff (rst)
      int'(deq_ack) <= int'(count));

endmodule

// File: rtl/fetch_queue.sv
// Compacting multi-in/multi-out instruction queue between pre-decode and decode.
// Define FETCH_QUEUE_PERF_EN to add saturating full/empty cycle counters.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int FETCH_WIDTH  = FETCH_WIDTH_D,
   parameter int DECODE_WIDTH = DECODE_WIDTH_D,
   parameter int DEPTH        = FQ_DEPTH_D,
   parameter int INDEX_W      = PHT_INDEX_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [FETCH_WIDTH-1:0]            enq_valid,
   input  logic [FETCH_WIDTH*32-1:0]         enq_pc,
   input  logic [FETCH_WIDTH*32-1:0]         enq_inst,
   input  logic [FETCH_WIDTH*32-1:0]         enq_target_unsel,
   input  logic [FETCH_WIDTH*INDEX_W-1:0]    enq_index,
   input  logic [FETCH_WIDTH-1:0]            enq_predict,
   output logic                              enq_ready,
   output logic [DECODE_WIDTH-1:0]           deq_valid,
   output logic [DECODE_WIDTH*32-1:0]        deq_pc,
   output logic [DECODE_WIDTH*32-1:0]        deq_inst,
   output logic [DECODE_WIDTH*32-1:0]        deq_target_unsel,
   output logic [DECODE_WIDTH*INDEX_W-1:0]   deq_index,
   output logic [DECODE_WIDTH-1:0]           deq_predict,
   input  logic [$clog2(DECODE_WIDTH+1)-1:0] deq_ack,
   output logic [$clog2(DEPTH+1)-1:0]        count
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]                       perf_full_cycles,
   output logic [31:0]                       perf_empty_cycles
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OFF_W = $clog2(FETCH_WIDTH + 1);

   fetch_entry_t                 mem_r [DEPTH];
   logic [PTR_W-1:0]             head_r, tail_r, head_next_s, tail_next_s;
   logic [CNT_W-1:0]             count_r, count_next_s, n_deq_s;
   logic                         enq_ready_r, enq_fire_s;
   logic [DECODE_WIDTH-1:0]      deq_valid_r;
   logic [FETCH_WIDTH*OFF_W-1:0] offset_s;
   logic [OFF_W-1:0]             n_enq_s;

   fetch_compact #(.WIDTH(FETCH_WIDTH), .OFF_W(OFF_W)) u_compact (
      .valid  (enq_valid),
      .offset (offset_s),
      .total  (n_enq_s)
   );

   fetch_queue_chk #(.CNT_W(CNT_W), .ACK_W($clog2(DECODE_WIDTH+1))) u_chk (
      .clk     (clk),
      .rst     (rst),
      .deq_ack (deq_ack),
      .count   (count_r)
   );

   assign enq_fire_s = enq_ready_r && (|enq_valid);

   // next pointers and occupancy; an over-sized ack is clamped to what is held
   always_comb begin
      n_deq_s = (int'(deq_ack) > int'(count_r)) ? count_r : CNT_W'(deq_ack);
      if (flush) begin
         head_next_s  = '0;
         tail_next_s  = '0;
         count_next_s = '0;
      end else if (enq_fire_s) begin
         head_next_s  = head_r + PTR_W'(n_deq_s);
         tail_next_s  = tail_r + PTR_W'(n_enq_s);
         count_next_s = count_r + CNT_W'(n_enq_s) - n_deq_s;
      end else begin
         head_next_s  = head_r + PTR_W'(n_deq_s);
         tail_next_s  = tail_r;
         count_next_s = count_r - n_deq_s;
      end
   end

   // storage writes, pointers and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         head_r      <= '0;
         tail_r      <= '0;
         count_r     <= '0;
         enq_ready_r <= 1'b1;
         deq_valid_r <= '0;
      end else begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq_fire_s && !flush && enq_valid[i]) begin
               mem_r[tail_r + PTR_W'(offset_s[i*OFF_W +: OFF_W])] <= '{
                  pc:           enq_pc[i*32 +: 32],
                  inst:         enq_inst[i*32 +: 32],
                  target_unsel: enq_target_unsel[i*32 +: 32],
                  index:        PHT_INDEX_W'(enq_index[i*INDEX_W +: INDEX_W]),
                  predict:      enq_predict[i]
               };
            end
         end
         head_r      <= head_next_s;
         tail_r      <= tail_next_s;
         count_r     <= count_next_s;
         enq_ready_r <= (DEPTH - int'(count_next_s)) >= FETCH_WIDTH;
         for (int j = 0; j < DECODE_WIDTH; j++) begin
            deq_valid_r[j] <= int'(count_next_s) > j;
         end
      end
   end

   for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_lane
      logic [PTR_W-1:0] rd_ptr_s;
      assign rd_ptr_s                       = head_r + PTR_W'(j);
      assign deq_pc[j*32 +: 32]             = mem_r[rd_ptr_s].pc;
      assign deq_inst[j*32 +: 32]           = mem_r[rd_ptr_s].inst;
      assign deq_target_unsel[j*32 +: 32]   = mem_r[rd_ptr_s].target_unsel;
      assign deq_index[j*INDEX_W +: INDEX_W] = INDEX_W'(mem_r[rd_ptr_s].index);
      assign deq_predict[j]                 = mem_r[rd_ptr_s].predict;
   end

   assign enq_ready = enq_ready_r;
   assign deq_valid = deq_valid_r;
   assign count     = count_r;

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_full_r, perf_empty_r;

   // saturating stall/empty counters; flush leaves them untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_full_r  <= 32'd0;
         perf_empty_r <= 32'd0;
      end else begin
         if (!enq_ready_r && (|enq_valid) && (perf_full_r != 32'hFFFF_FFFF)) begin
            perf_full_r <= perf_full_r + 32'd1;
         end
         if ((count_r == '0) && (perf_empty_r != 32'hFFFF_FFFF)) begin
            perf_empty_r <= perf_empty_r + 32'd1;
         end
      end
   end

   assign perf_full_cycles  = perf_full_r;
   assign perf_empty_cycles = perf_empty_r;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int FW = 3;
   localparam int DW = 3;
   localparam int DP = 16;
   localparam int IW = 10;

   logic           clk = 1'b0;
   logic           rst, flush;
   logic [FW-1:0]  enq_valid, enq_predict;
   logic [FW*32-1:0] enq_pc, enq_inst, enq_target_unsel;
   logic [FW*IW-1:0] enq_index;
   logic           enq_ready;
   logic [DW-1:0]  deq_valid, deq_predict;
   logic [DW*32-1:0] deq_pc, deq_inst, deq_target_unsel;
   logic [DW*IW-1:0] deq_index;
   logic [1:0]     deq_ack;
   logic [4:0]     count;
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0]    perf_full_cycles, perf_empty_cycles;
`endif

   fetch_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_inst(enq_inst),
      .enq_target_unsel(enq_target_unsel), .enq_index(enq_index), .enq_predict(enq_predict),
      .enq_ready(enq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_inst(deq_inst),
      .deq_target_unsel(deq_target_unsel), .deq_index(deq_index), .deq_predict(deq_predict),
      .deq_ack(deq_ack), .count(count)
`ifdef FETCH_QUEUE_PERF_EN
      , .perf_full_cycles(perf_full_cycles), .perf_empty_cycles(perf_empty_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  cnt;
      logic        rdy;
      logic [2:0]  dv;
      logic        zero;
      logic [95:0] pc;
      logic [95:0] inst;
      logic [95:0] tgt;
      logic [29:0] idx;
      logic [2:0]  pred;
      logic [31:0] pfull;
      logic [31:0] pempty;
   } exp_t;

   exp_t         exp_q [$];
   fetch_entry_t mq [$];
   int           errors = 0;
   int           checks = 0;
   logic [31:0]  pf_m = 32'd0;
   logic [31:0]  pe_m = 32'd0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, advance the model, queue the expected post-edge view.
   task automatic step(input bit r, input bit f, input logic [2:0] v,
                       input logic [1:0] ack, input logic [31:0] pc0);
      exp_t         e;
      bit           fire;
      fetch_entry_t ent;
      rst = r; flush = f; enq_valid = v; deq_ack = ack;
      for (int i = 0; i < FW; i++) begin
         enq_pc[i*32 +: 32]           = pc0 + 32'(4 * i);
         enq_inst[i*32 +: 32]         = $urandom;
         enq_target_unsel[i*32 +: 32] = $urandom;
         enq_index[i*IW +: IW]        = 10'($urandom);
         enq_predict[i]               = 1'($urandom);
      end
      if (r) begin
         pf_m = 32'd0;
         pe_m = 32'd0;
      end else begin
         if (!((DP - mq.size()) >= FW) && (v != 3'b000) && pf_m != 32'hFFFF_FFFF) pf_m++;
         if (mq.size() == 0 && pe_m != 32'hFFFF_FFFF) pe_m++;
      end
      if (r || f) begin
         mq.delete();
      end else begin
         fire = ((DP - mq.size()) >= FW) && (v != 3'b000);
         for (int k = 0; k < int'(ack); k++) if (mq.size() > 0) void'(mq.pop_front());
         if (fire) begin
            for (int i = 0; i < FW; i++) begin
               if (v[i]) begin
                  ent.pc           = enq_pc[i*32 +: 32];
                  ent.inst         = enq_inst[i*32 +: 32];
                  ent.target_unsel = enq_target_unsel[i*32 +: 32];
                  ent.index        = enq_index[i*IW +: IW];
                  ent.predict      = enq_predict[i];
                  mq.push_back(ent);
               end
            end
         end
      end
      e = '0;
      e.cnt  = 5'(mq.size());
      e.rdy  = (DP - mq.size()) >= FW;
      e.zero = r;
      for (int j = 0; j < DW; j++) begin
         e.dv[j] = mq.size() > j;
         if (j < mq.size()) begin
            e.pc[j*32 +: 32]   = mq[j].pc;
            e.inst[j*32 +: 32] = mq[j].inst;
            e.tgt[j*32 +: 32]  = mq[j].target_unsel;
            e.idx[j*IW +: IW]  = mq[j].index;
            e.pred[j]          = mq[j].predict;
         end
      end
      e.pfull  = pf_m;
      e.pempty = pe_m;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: after every active edge compare the DUT view with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 64'(count), 64'(e.cnt));
            chk("enq_ready", 64'(enq_ready), 64'(e.rdy));
            chk("deq_valid", 64'(deq_valid), 64'(e.dv));
            for (int j = 0; j < DW; j++) begin
               if (e.zero || j < int'(e.cnt)) begin
                  chk($sformatf("deq_pc[%0d]", j), 64'(deq_pc[j*32 +: 32]), 64'(e.pc[j*32 +: 32]));
                  chk($sformatf("deq_inst[%0d]", j), 64'(deq_inst[j*32 +: 32]), 64'(e.inst[j*32 +: 32]));
                  chk($sformatf("deq_tgt[%0d]", j), 64'(deq_target_unsel[j*32 +: 32]), 64'(e.tgt[j*32 +: 32]));
                  chk($sformatf("deq_index[%0d]", j), 64'(deq_index[j*IW +: IW]), 64'(e.idx[j*IW +: IW]));
                  chk($sformatf("deq_predict[%0d]", j), 64'(deq_predict[j]), 64'(e.pred[j]));
               end
            end
`ifdef FETCH_QUEUE_PERF_EN
            chk("perf_full", 64'(perf_full_cycles), 64'(e.pfull));
            chk("perf_empty", 64'(perf_empty_cycles), 64'(e.pempty));
`endif
         end
      end
   end

   initial begin
      int lim;
      // sparse enqueue, then fill to stall and hold while full
      step(1'b1, 1'b0, 3'b000, 2'd0, 32'h0);
      step(1'b0, 1'b0, 3'b101, 2'd0, 32'h1c00_0000);
      step(1'b1, 1'b0, 3'b000, 2'd0, 32'h0);
      for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 3'b111, 2'd0, 32'h2000_0000 + 32'(c * 16));
      for (int c = 0; c < 7; c++) step(1'b0, 1'b0, 3'b111, 2'd0, 32'h2100_0000);
      step(1'b0, 1'b1, 3'b000, 2'd0, 32'h0);
      step(1'b0, 1'b0, 3'b000, 2'd0, 32'h0);
      // pointer wrap: move head/tail to 14, then enqueue across the wrap point
      step(1'b1, 1'b0, 3'b000, 2'd0, 32'h0);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 3'b111, 2'd0, 32'h3000_0000 + 32'(c * 16));
      step(1'b0, 1'b0, 3'b011, 2'd0, 32'h3000_0040);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 3'b000, 2'd3, 32'h0);
      step(1'b0, 1'b0, 3'b000, 2'd2, 32'h0);
      step(1'b0, 1'b0, 3'b111, 2'd0, 32'h4000_0000);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 3'b000, 2'd1, 32'h0);
      // simultaneous enqueue and dequeue at count 4
      step(1'b1, 1'b0, 3'b000, 2'd0, 32'h0);
      step(1'b0, 1'b0, 3'b111, 2'd0, 32'h5000_0000);
      step(1'b0, 1'b0, 3'b001, 2'd0, 32'h5000_0010);
      step(1'b0, 1'b0, 3'b111, 2'd2, 32'h5000_0020);
      // flush beats a concurrent enqueue and dequeue at count 9
      step(1'b1, 1'b0, 3'b000, 2'd0, 32'h0);
      for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 3'b111, 2'd0, 32'h6000_0000 + 32'(c * 16));
      step(1'b0, 1'b1, 3'b111, 2'd3, 32'h6000_0040);
      step(1'b0, 1'b0, 3'b000, 2'd0, 32'h0);
      // random traffic with legal acknowledges, occasional flush and reset
      for (int c = 0; c < 800; c++) begin
         lim = (mq.size() < 3) ? mq.size() : 3;
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
              3'($urandom), 2'($urandom_range(0, lim)), $urandom & 32'hFFFF_FFFC);
      end
      @(posedge clk);
      #2;
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
